// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 20;
  localparam int MEM_BYTES_DEF     = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on contention the
// requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);

  // Combinational winner selection from the request pair and last-served index.
  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single data-memory port. One transaction
// takes IDLE -> SERVE -> DONE; fields are latched at grant so requesters may
// wiggle req while a transaction is in flight without disturbing it.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int MEM_BYTES     = MEM_BYTES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0]                 we,
  input  logic [1:0]                 be,
  input  logic [2*ADDRESS_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0]    wdata,
  output logic [1:0]                 done,
  output logic                       err,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDRESS_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]      mem_write_data,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic                       mem_be,
  input  logic [DATA_WIDTH-1:0]      mem_read_data
);

  // One extra bit so the limit itself is representable when it equals 2**ADDRESS_WIDTH.
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_BYTES);

  state_e                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      g_q, g_d;
  logic                      we_q, we_d;
  logic                      be_q, be_d;
  logic                      oor_q, oor_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [1:0]                done_q, done_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      mem_we_q, mem_we_d;
  logic                      mem_re_q, mem_re_d;

  logic                      arb_valid;
  logic                      arb_gnt;
  logic                      sel_oor;
  logic [ADDRESS_WIDTH-1:0]  addr_s  [2];
  logic [DATA_WIDTH-1:0]     wdata_s [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      assign addr_s[gi]  = addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign wdata_s[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

  assign sel_oor = ({1'b0, addr_s[arb_gnt]} >= MEM_LIMIT);

  // Next-state and next-output computation for the three-phase transaction.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    g_d      = g_q;
    we_d     = we_q;
    be_d     = be_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = 2'b00;
    err_d    = 1'b0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          g_d      = arb_gnt;
          we_d     = we[arb_gnt];
          be_d     = be[arb_gnt];
          addr_d   = addr_s[arb_gnt];
          wdata_d  = wdata_s[arb_gnt];
          oor_d    = sel_oor;
          // Strobes are registered so they are high exactly during SERVE.
          mem_we_d = we[arb_gnt] & ~sel_oor;
          mem_re_d = ~we[arb_gnt] & ~sel_oor;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        rdata_d      = (we_q || oor_q) ? '0 : mem_read_data;
        done_d[g_q]  = 1'b1;
        err_d        = oor_q;
        state_d      = DONE;
      end
      DONE: begin
        last_d  = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also kills any in-flight memory strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      g_q      <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      g_q      <= g_d;
      we_q     <= we_d;
      be_q     <= be_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
    end
  end

  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_be         = be_q;
  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level reference model
// and a behavioural data memory (byte lane = address[1:0], byte reads zero-extended).
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int MB = 4096;
  localparam int NW = MB / 4;

  typedef struct {
    logic          we;
    logic          be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0]      we = 2'b00;
  logic [1:0]      be = 2'b00;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      done;
  logic            err;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_we;
  logic            mem_re;
  logic            mem_be;
  logic [DW-1:0]   mem_read_data;

  logic [31:0]     env_mem [NW];
  logic [31:0]     ref_mem [NW];
  int              n_checks = 0;
  int              n_fail = 0;
  int              last_ref = 1;
  logic [DW-1:0]   last_rdata;
  txn_t            q0[$];
  txn_t            q1[$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .we             (we),
    .be             (be),
    .addr           (addr),
    .wdata          (wdata),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_be         (mem_be),
    .mem_read_data  (mem_read_data)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  always_comb begin
    mem_read_data = '0;
    if (32'(mem_address) < MB) begin
      if (mem_be) mem_read_data = {24'd0, env_mem[mem_address[11:2]][8*int'(mem_address[1:0]) +: 8]};
      else        mem_read_data = env_mem[mem_address[11:2]];
    end
  end

  initial begin
    for (int i = 0; i < NW; i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    env_mem[1] = 32'hDEADBEEF;
    ref_mem[1] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (mem_we && 32'(mem_address) < MB) begin
        if (mem_be) env_mem[mem_address[11:2]][8*int'(mem_address[1:0]) +: 8] <= mem_write_data[7:0];
        else        env_mem[mem_address[11:2]] <= mem_write_data;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.be    = 1'($urandom_range(0, 1));
    t.wdata = $urandom();
    case ($urandom_range(0, 7))
      0:       t.addr = AW'($urandom_range(MB, (1 << AW) - 1));
      1, 2, 3: t.addr = AW'($urandom_range(0, MB - 1));
      default: t.addr = AW'($urandom_range(0, 31));
    endcase
    if (!t.be) t.addr[1:0] = 2'b00;
    return t;
  endfunction

  function automatic txn_t mk(input logic w, input logic b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = w; t.be = b; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Runs every queued transaction. The model: the arbiter looks at req on a
  // free edge, a granted transaction shows done two cycles later with the
  // memory strobe in the cycle before, and the next look is three edges after
  // the grant. dly[i] delays requester i's first req; tog_k pulses req[1]
  // for one cycle only.
  task automatic run_round(input int dly0, input int dly1, input int tog_k);
    int            dly[2];
    bit            act[2];
    txn_t          cur[2];
    txn_t          wt;
    int            busy, done_k, win, k;
    bit            oor;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            idx, lane;
    dly[0] = dly0; dly[1] = dly1;
    act[0] = (q0.size() > 0);
    act[1] = (q1.size() > 0);
    if (act[0]) cur[0] = q0.pop_front();
    if (act[1]) cur[1] = q1.pop_front();
    busy = 0; done_k = -1; win = 0; oor = 1'b0; exp_rd = '0; exp_err = 1'b0;
    wt = mk(1'b0, 1'b0, '0, '0);
    for (k = 0; k < 100 && (act[0] || act[1] || done_k >= k); k++) begin
      @(negedge clk);
      check("done", {62'd0, done}, (k == done_k) ? 64'(1 << win) : 64'd0);
      check("mem_we", {63'd0, mem_we}, {63'd0, (k == done_k - 1) && wt.we && !oor});
      check("mem_re", {63'd0, mem_re}, {63'd0, (k == done_k - 1) && !wt.we && !oor});
      if (k == done_k) begin
        check("err", {63'd0, err}, {63'd0, exp_err});
        check("rdata", {32'd0, rdata}, {32'd0, exp_rd});
        last_rdata = rdata;
        if (win == 0) begin
          if (q0.size() > 0) cur[0] = q0.pop_front(); else act[0] = 0;
        end else begin
          if (q1.size() > 0) cur[1] = q1.pop_front(); else act[1] = 0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        req[i] = act[i] && (k >= dly[i]);
        if (act[i]) begin
          we[i] = cur[i].we;
          be[i] = cur[i].be;
          addr[i*AW +: AW] = cur[i].addr;
          wdata[i*DW +: DW] = cur[i].wdata;
        end
      end
      if (k == tog_k) req[1] = 1'b1;
      if (k >= busy && req != 2'b00) begin
        if (req == 2'b11) win = 1 - last_ref;
        else              win = req[1] ? 1 : 0;
        wt       = cur[win];
        last_ref = win;
        done_k   = k + 2;
        busy     = k + 3;
        oor      = (32'(wt.addr) >= MB);
        idx      = int'(wt.addr[11:2]);
        lane     = int'(wt.addr[1:0]);
        exp_err  = oor;
        exp_rd   = '0;
        if (!oor) begin
          if (wt.we) begin
            if (wt.be) ref_mem[idx][8*lane +: 8] = wt.wdata[7:0];
            else       ref_mem[idx] = wt.wdata;
          end else begin
            exp_rd = wt.be ? {24'd0, ref_mem[idx][8*lane +: 8]} : ref_mem[idx];
          end
        end
      end
    end
    if (act[0] || act[1] || done_k >= k) check("round_timeout", 64'd1, 64'd0);
    req = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", {62'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_mem_address", {44'd0, mem_address}, 64'd0);
    check("rst_mem_write_data", {32'd0, mem_write_data}, 64'd0);
    check("rst_mem_strobes", {61'd0, mem_we, mem_re, mem_be}, 64'd0);
    rst = 1'b1;
    last_ref = 1;

    // Continuous contention right after reset: order 0,1,0,1
    q0.push_back(mk(1'b0, 1'b0, 20'h00004, '0));
    q0.push_back(rand_txn());
    q1.push_back(rand_txn());
    q1.push_back(rand_txn());
    run_round(0, 0, -1);

    // Single word read of 0x0004
    q0.push_back(mk(1'b0, 1'b0, 20'h00004, '0));
    run_round(0, 0, -1);
    check("read_deadbeef", {32'd0, last_rdata}, 64'hDEADBEEF);

    // Byte store from requester 1, then word read back
    q1.push_back(mk(1'b1, 1'b1, 20'h00006, 32'h000000AB));
    run_round(0, 0, -1);
    q0.push_back(mk(1'b0, 1'b0, 20'h00004, '0));
    run_round(0, 0, -1);
    check("sbp_lane2", {56'd0, last_rdata[23:16]}, 64'hAB);

    // Out-of-range read
    q0.push_back(mk(1'b0, 1'b0, 20'h01000, '0));
    run_round(0, 0, -1);

    // req[1] pulses during requester 0's SERVE/DONE, then requests for real
    q0.push_back(rand_txn());
    q1.push_back(rand_txn());
    run_round(0, 3, 1);

    // Reset in the SERVE cycle of a word write
    @(negedge clk);
    req = 2'b01; we = 2'b01; be = 2'b00;
    addr[AW-1:0] = 20'h00008; wdata[DW-1:0] = 32'h12345678;
    @(negedge clk);
    check("serve_mem_we", {63'd0, mem_we}, 64'd1);
    rst = 1'b0;
    #1;
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    check("abort_outputs", {done, err, mem_re, mem_be}, 64'd0);
    check("abort_mem_address", {44'd0, mem_address}, 64'd0);
    check("abort_mem_write_data", {32'd0, mem_write_data}, 64'd0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("abort_word_kept", {32'd0, env_mem[2]}, {32'd0, ref_mem[2]});
    rst = 1'b1;
    last_ref = 1;
    q0.push_back(mk(1'b0, 1'b0, 20'h00008, '0));
    run_round(0, 0, -1);

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int j = 0; j < n0; j++) q0.push_back(rand_txn());
      for (int j = 0; j < n1; j++) q1.push_back(rand_txn());
      run_round($urandom_range(0, 4), $urandom_range(0, 4), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
